e2prom_rw_ctrl: RTL and testbench

E2PROM_RW_CTRL -- requirements
Module: e2prom_rw_ctrl

---
 rtl/e2prom_rw_ctrl.sv | 151 +++++++++++++++
 tb/tb_e2prom_rw_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/e2prom_rw_ctrl.sv
// E2PROM write-then-readback test controller that sequences transactions for an I2C byte driver.
// Optional macro E2PROM_ACK_CHECK_EN: a NACK reported with i2c_done also marks the run as failed.

module e2prom_rw_ctrl #(
  parameter int unsigned BYTE_NUM = 16,
  parameter int unsigned WAIT_CYC = 1250,
  parameter bit          ADDR16   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        i2c_done,
  input  logic        i2c_ack,
  input  logic [7:0]  i2c_data_r,
  output logic        i2c_exec,
  output logic        i2c_rh_wl,
  output logic [15:0] i2c_addr,
  output logic [7:0]  i2c_data_w,
  output logic        bit_ctrl,
  output logic        rw_done,
  output logic        rw_pass
);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_BUSY, WR_GAP, RD_REQ, RD_BUSY, FINISH
  } state_t;

  localparam logic [15:0] ADDR_LAST = 16'(BYTE_NUM - 1);
  localparam logic [31:0] GAP_LAST  = (WAIT_CYC > 0) ? 32'(WAIT_CYC - 1) : 32'd0;

  state_t      state, state_nx;
  logic [15:0] addr_cnt, addr_cnt_nx;
  logic [31:0] gap_cnt, gap_cnt_nx;
  logic        err, err_nx;
  logic        exec_nx, rh_wl_nx, done_nx, pass_nx;
  logic [15:0] addr_nx;
  logic [7:0]  data_w_nx;
  logic [15:0] issue_addr;
  logic        ack_err;

`ifdef E2PROM_ACK_CHECK_EN
  assign ack_err = i2c_ack;
`else
  logic unused_ack;
  assign unused_ack = i2c_ack;
  assign ack_err    = 1'b0;
`endif

  assign bit_ctrl = ADDR16;

  // In 8-bit addressing mode the upper address byte is never presented to the driver.
  assign issue_addr = ADDR16 ? addr_cnt : {8'h00, addr_cnt[7:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_cnt   <= '0;
      gap_cnt    <= '0;
      err        <= 1'b0;
      i2c_exec   <= 1'b0;
      i2c_rh_wl  <= 1'b0;
      i2c_addr   <= '0;
      i2c_data_w <= '0;
      rw_done    <= 1'b0;
      rw_pass    <= 1'b0;
    end else begin
      state      <= state_nx;
      addr_cnt   <= addr_cnt_nx;
      gap_cnt    <= gap_cnt_nx;
      err        <= err_nx;
      i2c_exec   <= exec_nx;
      i2c_rh_wl  <= rh_wl_nx;
      i2c_addr   <= addr_nx;
      i2c_data_w <= data_w_nx;
      rw_done    <= done_nx;
      rw_pass    <= pass_nx;
    end
  end

  // Transaction fields are captured together with the exec pulse and held until the next request.
  always_comb begin
    state_nx    = state;
    addr_cnt_nx = addr_cnt;
    gap_cnt_nx  = gap_cnt;
    err_nx      = err;
    exec_nx     = 1'b0;
    rh_wl_nx    = i2c_rh_wl;
    addr_nx     = i2c_addr;
    data_w_nx   = i2c_data_w;

    case (state)
      IDLE, FINISH: begin
        if (start) begin
          addr_cnt_nx = '0;
          err_nx      = 1'b0;
          state_nx    = WR_REQ;
        end
      end
      WR_REQ: begin
        exec_nx   = 1'b1;
        rh_wl_nx  = 1'b0;
        addr_nx   = issue_addr;
        data_w_nx = addr_cnt[7:0];
        state_nx  = WR_BUSY;
      end
      WR_BUSY: begin
        if (i2c_done) begin
          if (ack_err) err_nx = 1'b1;
          gap_cnt_nx = '0;
          state_nx   = WR_GAP;
        end
      end
      WR_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          if (addr_cnt == ADDR_LAST) begin
            addr_cnt_nx = '0;
            state_nx    = RD_REQ;
          end else begin
            addr_cnt_nx = addr_cnt + 16'd1;
            state_nx    = WR_REQ;
          end
        end else begin
          gap_cnt_nx = gap_cnt + 32'd1;
        end
      end
      RD_REQ: begin
        exec_nx   = 1'b1;
        rh_wl_nx  = 1'b1;
        addr_nx   = issue_addr;
        data_w_nx = addr_cnt[7:0];
        state_nx  = RD_BUSY;
      end
      RD_BUSY: begin
        if (i2c_done) begin
          if (i2c_data_r != addr_cnt[7:0] || ack_err) err_nx = 1'b1;
          if (addr_cnt == ADDR_LAST) begin
            state_nx = FINISH;
          end else begin
            addr_cnt_nx = addr_cnt + 16'd1;
            state_nx    = RD_REQ;
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    done_nx = (state_nx == FINISH);
    pass_nx = done_nx & ~err_nx;
  end

endmodule

// File: tb/tb_e2prom_rw_ctrl.sv
// Self-checking bench for e2prom_rw_ctrl: an E2PROM/driver responder with randomized latency and faults.
// Expected results come from a transaction-level model (write 0..N-1, read 0..N-1, pass = no faults).

module tb_e2prom_rw_ctrl;

  localparam int BYTE_NUM = 4;
  localparam int WAIT_CYC = 8;
  localparam int LIMIT    = WAIT_CYC + 20;

`ifdef E2PROM_ACK_CHECK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        i2c_done = 1'b0;
  logic        i2c_ack = 1'b0;
  logic [7:0]  i2c_data_r = 8'h00;
  logic        i2c_exec;
  logic        i2c_rh_wl;
  logic [15:0] i2c_addr;
  logic [7:0]  i2c_data_w;
  logic        bit_ctrl;
  logic        rw_done;
  logic        rw_pass;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  e2prom_rw_ctrl #(
    .BYTE_NUM(BYTE_NUM),
    .WAIT_CYC(WAIT_CYC),
    .ADDR16  (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .i2c_done  (i2c_done),
    .i2c_ack   (i2c_ack),
    .i2c_data_r(i2c_data_r),
    .i2c_exec  (i2c_exec),
    .i2c_rh_wl (i2c_rh_wl),
    .i2c_addr  (i2c_addr),
    .i2c_data_w(i2c_data_w),
    .bit_ctrl  (bit_ctrl),
    .rw_done   (rw_done),
    .rw_pass   (rw_pass)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    start = 1'b0;
    i2c_done = 1'b0;
    i2c_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One complete test run. mis_mask: read addresses answered with wrong data.
  // nack_mask bits [3:0]: NACK on write addr, bits [7:4]: NACK on read addr.
  task automatic applyStimulus(input logic [15:0] mis_mask, input logic [7:0] nack_mask,
                               input bit spur, input int rst_k, input bit rand_start,
                               output bit aborted);
    int          done_cyc;
    int          exp_gap;
    int          lat;
    int          n;
    bit          is_rd;
    bit          hold_ok;
    bit          saw_exec;
    bit          exp_pass;
    logic [15:0] ea;
    logic [15:0] ha;
    logic [7:0]  hd;
    logic        hr;

    aborted  = 1'b0;
    exp_pass = (mis_mask == 16'h0) && !(ACK_EN && nack_mask != 8'h0);

    @(negedge clk);
    start    = 1'b1;
    done_cyc = cyc;
    @(negedge clk);
    start    = 1'b0;
    exp_gap  = 2;

    for (int k = 0; k < 2 * BYTE_NUM; k++) begin
      is_rd = (k >= BYTE_NUM);
      ea    = 16'(k % BYTE_NUM);

      for (n = 0; n < LIMIT; n++) begin
        if (i2c_exec) break;
        if (spur && k == 2 && n == 3) begin
          i2c_done   = 1'b1;
          i2c_ack    = 1'b1;
          i2c_data_r = 8'h5A;
        end else begin
          i2c_done = 1'b0;
          i2c_ack  = 1'b0;
        end
        @(negedge clk);
      end
      i2c_done = 1'b0;
      i2c_ack  = 1'b0;
      if (!i2c_exec) begin
        checkOutput($sformatf("exec_timeout_k%0d", k), 32'd0, 32'd1);
        aborted = 1'b1;
        return;
      end

      checkOutput($sformatf("gap_k%0d", k), 32'(cyc - done_cyc), 32'(exp_gap));
      checkOutput($sformatf("rh_wl_k%0d", k), 32'(i2c_rh_wl), 32'(is_rd));
      checkOutput($sformatf("addr_k%0d", k), 32'(i2c_addr), 32'(ea));
      if (!is_rd) checkOutput($sformatf("wdata_k%0d", k), 32'(i2c_data_w), 32'(ea[7:0]));
      if (k == 0) checkOutput("done_low_in_run", 32'(rw_done), 32'd0);
      ha = i2c_addr;
      hd = i2c_data_w;
      hr = i2c_rh_wl;

      @(negedge clk);
      checkOutput($sformatf("exec_width_k%0d", k), 32'(i2c_exec), 32'd0);

      if (k == rst_k) begin
        #2 rst_n = 1'b0;
        #1 checkOutput("rst_outputs",
                       32'({i2c_exec, i2c_rh_wl, i2c_addr, i2c_data_w, rw_done, rw_pass}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_exec = 1'b0;
        repeat (6) begin
          @(negedge clk);
          saw_exec |= i2c_exec;
        end
        checkOutput("rst_stays_idle", 32'(saw_exec), 32'd0);
        aborted = 1'b1;
        return;
      end

      hold_ok = 1'b1;
      lat = int'($urandom_range(0, 4));
      for (int j = 0; j < lat; j++) begin
        if (rand_start) start = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (i2c_exec || i2c_addr != ha || i2c_data_w != hd || i2c_rh_wl != hr) hold_ok = 1'b0;
      end
      checkOutput($sformatf("busy_hold_k%0d", k), 32'(hold_ok), 32'd1);

      start    = 1'b0;
      i2c_done = 1'b1;
      i2c_ack  = is_rd ? nack_mask[4 + int'(ea)] : nack_mask[int'(ea)];
      if (!is_rd)               i2c_data_r = 8'($urandom);
      else if (mis_mask[ea])    i2c_data_r = (ea[7:0] != 8'hFF) ? 8'hFF : 8'h00;
      else                      i2c_data_r = ea[7:0];
      done_cyc = cyc;
      @(negedge clk);
      i2c_done = 1'b0;
      i2c_ack  = 1'b0;
      exp_gap  = is_rd ? 2 : WAIT_CYC + 2;
    end

    checkOutput("rw_done", 32'(rw_done), 32'd1);
    checkOutput("rw_pass", 32'(rw_pass), 32'(exp_pass));
    saw_exec = 1'b0;
    repeat (3) begin
      @(negedge clk);
      saw_exec |= i2c_exec;
    end
    checkOutput("finish_hold", 32'({rw_done, saw_exec}), 32'd2);
  endtask

  initial begin
    bit          ab;
    logic [15:0] mm;
    logic [7:0]  nm;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs",
                32'({i2c_exec, i2c_rh_wl, i2c_addr, i2c_data_w, rw_done, rw_pass}), 32'd0);
    checkOutput("bit_ctrl", 32'(bit_ctrl), 32'd1);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("idle_without_start", 32'({i2c_exec, rw_done}), 32'd0);

    applyStimulus(16'h0000, 8'h00, 1'b0, -1, 1'b0, ab);
    applyStimulus(16'h0004, 8'h00, 1'b0, -1, 1'b0, ab);
    applyStimulus(16'h0000, 8'h02, 1'b0, -1, 1'b0, ab);
    applyStimulus(16'h0000, 8'h00, 1'b1, -1, 1'b0, ab);
    applyStimulus(16'h0000, 8'h00, 1'b0, 1, 1'b0, ab);
    applyStimulus(16'h0000, 8'h00, 1'b0, -1, 1'b0, ab);

    for (int r = 0; r < 8; r++) begin
      if (ab) resetDut();
      mm = ($urandom_range(0, 1) == 0) ? 16'h0 : 16'($urandom_range(0, 15));
      nm = ($urandom_range(0, 1) == 0) ? 8'h0  : 8'($urandom_range(0, 255));
      applyStimulus(mm, nm, 1'($urandom_range(0, 1)), -1, 1'b1, ab);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
